mem_arbiter: RTL and testbench

- Arbitrates the single unified RAM port between the instruction-fetch requester and the data-memory requester of the pipelined core.
- Sits between the datapath's i/d memory requests and the RAM model. Its iwait/dwait outputs feed dpif_ihit/dpif_dhit, which the hazard unit consumes for pc_WEN and pipe_stall.
- Data requests have priority. A starvation counter guarantees forward progress for fetch, and a timeout counter guarantees that a request stuck on the RAM still completes.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_sat_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-RAM arbiter.
package mem_arbiter_pkg;

  // RAM handshake state returned by the RAM model.
  typedef logic [1:0] ramstate_t;
  localparam ramstate_t RAM_FREE   = 2'd0;
  localparam ramstate_t RAM_BUSY   = 2'd1;
  localparam ramstate_t RAM_ACCESS = 2'd2;
  localparam ramstate_t RAM_ERROR  = 2'd3;

  // Arbiter ownership state; the registered state is the current owner.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_SERVE_I = 2'd1;
  localparam arb_state_t ARB_SERVE_D = 2'd2;

  // Default limits.
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;
  localparam int CW_DEF           = 8;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; used for timeout and starvation tracking.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // Clear has priority over increment; the count holds at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single RAM port shared by instruction fetch and data access.
// Data has priority; a starvation counter forces fetch after repeated data
// grants, and a timeout counter forces completion of a stuck request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_mem_err;
  logic [CW-1:0] w_tcnt;
  logic [CW-1:0] w_scnt;

  logic w_d_req, w_serving, w_owner_req, w_access, w_error;
  logic w_timeout, w_done, w_fail, w_abort, w_starved;
  logic w_t_clr, w_t_inc, w_s_clr, w_s_inc;

  assign w_d_req     = dREN | dWEN;
  assign w_serving   = (r_state == ARB_SERVE_I) || (r_state == ARB_SERVE_D);
  assign w_owner_req = ((r_state == ARB_SERVE_I) && iREN) ||
                       ((r_state == ARB_SERVE_D) && w_d_req);
  assign w_access    = (ramstate == RAM_ACCESS);
  assign w_error     = (ramstate == RAM_ERROR);
  // The count lags the serve cycle by one, so the TIMEOUT-th serve cycle sees TIMEOUT-1.
  assign w_timeout   = (int'(w_tcnt) + 1) >= TIMEOUT;
  assign w_done      = w_owner_req && (w_access || w_error || w_timeout);
  // A simultaneous ACCESS wins over a timeout: the data is good.
  assign w_fail      = w_done && !w_access;
  // Owner withdrew its request (pipeline flush): release the port silently.
  assign w_abort     = w_serving && !w_owner_req;
  assign w_starved   = iREN && (int'(w_scnt) >= STARVE_LIMIT);

  assign w_t_clr = (r_state == ARB_IDLE) && (w_next != ARB_IDLE);
  assign w_t_inc = w_owner_req && !w_access && !w_error;
  assign w_s_inc = (r_state == ARB_SERVE_D) && w_done && iREN;
  assign w_s_clr = ((r_state == ARB_SERVE_I) && w_done) ||
                   ((r_state == ARB_SERVE_D) && w_done && !iREN);

  sat_counter #(.CW(CW)) u_timeout (
    .i_clk (CLK),
    .i_rst (RST),
    .i_clr (w_t_clr),
    .i_inc (w_t_inc),
    .o_cnt (w_tcnt)
  );

  sat_counter #(.CW(CW)) u_starve (
    .i_clk (CLK),
    .i_rst (RST),
    .i_clr (w_s_clr),
    .i_inc (w_s_inc),
    .o_cnt (w_scnt)
  );

  // Next owner: every serve returns through IDLE so a held request is never re-granted stale.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_d_req && !w_starved) begin
          w_next = ARB_SERVE_D;
        end else if (iREN) begin
          w_next = ARB_SERVE_I;
        end else begin
          w_next = ARB_IDLE;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (w_done || w_abort) begin
          w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // RAM port mux and requester handshake, driven straight from the owner's request.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (r_state)
      ARB_SERVE_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (w_done) begin
          iwait = 1'b0;
          iload = w_access ? ramload : 32'h0;
        end
      end
      ARB_SERVE_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (w_done) begin
          dwait = 1'b0;
          dload = w_access ? ramload : 32'h0;
        end
      end
      default: ;
    endcase
  end

  // Owner register and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ARB_IDLE;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fail) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8), .CW(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .mem_err  (mem_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sbq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit is_d, input logic [31:0] data, input int at);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input bit is_d, input logic [31:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_completion: got %s load 0x%08h at cycle %0d, expected none",
               is_d ? "data" : "fetch", data, cyc);
    end else begin
      e = sbq.pop_front();
      chk("completion_kind", {31'b0, is_d}, {31'b0, e.is_d});
      chk(is_d ? "dload" : "iload", data, e.data);
      chk("completion_cycle", cyc, e.at);
    end
  endtask

  // Monitor: every low wait is a completion that must match the scoreboard head.
  always @(negedge CLK) begin
    if (!iwait) pop_chk(1'b0, iload);
    if (!dwait) pop_chk(1'b1, dload);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h1111_0000; daddr = 32'h1234; dstore = 32'hFFFF;
    ramload = 32'hABCD_0000; ramstate = FREE;

    // Reset state
    step(); step(); #1;
    chk("rst_ramREN", {31'b0, ramREN}, 0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_iwait", {31'b0, iwait}, 1);
    chk("rst_dwait", {31'b0, dwait}, 1);
    chk("rst_mem_err", {31'b0, mem_err}, 0);
    step(); RST = 1'b0; iREN = 1'b0; dREN = 1'b0;
    step();

    // Single fetch, ACCESS on second serve cycle
    step(); base = cyc; iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 0;
    #1; chk("sf_idle_ramREN", {31'b0, ramREN}, 0);
    chk("sf_idle_iwait", {31'b0, iwait}, 1);
    step(); #1; chk("sf_c1_ramREN", {31'b0, ramREN}, 1);
    chk("sf_c1_ramaddr", ramaddr, 32'h40);
    step(); ramstate = ACCESS; ramload = 32'h8C22_0004;
    expect_resp(1'b0, 32'h8C22_0004, base + 2);
    #1; chk("sf_c2_ramREN", {31'b0, ramREN}, 1);
    step(); iREN = 1'b0; ramstate = FREE;
    #1; chk("sf_c3_ramREN", {31'b0, ramREN}, 0);

    // Contention: data first, one-cycle gap, then fetch
    step(); base = cyc; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'h1111_1111;
    #1; chk("ct_idle_ramREN", {31'b0, ramREN}, 0);
    step(); expect_resp(1'b1, 32'h1111_1111, base + 1);
    #1; chk("ct_d_ramaddr", ramaddr, 32'h100);
    chk("ct_d_iwait", {31'b0, iwait}, 1);
    step(); dREN = 1'b0; ramload = 32'h2222_2222;
    #1; chk("ct_gap_ramREN", {31'b0, ramREN}, 0);
    step(); expect_resp(1'b0, 32'h2222_2222, base + 3);
    #1; chk("ct_i_ramaddr", ramaddr, 32'h80);
    step(); iREN = 1'b0;

    // Starvation: four data writes, forced fetch, then the fifth write
    step(); base = cyc;
    expect_resp(1'b1, 32'h1001, base + 1);
    expect_resp(1'b1, 32'h1003, base + 3);
    expect_resp(1'b1, 32'h1005, base + 5);
    expect_resp(1'b1, 32'h1007, base + 7);
    expect_resp(1'b0, 32'h1009, base + 9);
    expect_resp(1'b1, 32'h100B, base + 11);
    iaddr = 32'h200;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      iREN = (k <= 9);
      dWEN = 1'b1;
      daddr = 32'h300 + k;
      dstore = k;
      ramstate = ACCESS;
      ramload = 32'h1000 + k;
      if (k == 9) begin
        #1;
        chk("st_fetch_dwait", {31'b0, dwait}, 1);
        chk("st_fetch_ramWEN", {31'b0, ramWEN}, 0);
        chk("st_fetch_ramaddr", ramaddr, 32'h200);
      end
    end
    step(); dWEN = 1'b0; iREN = 1'b0;

    // Timeout on BUSY, then a clean access with mem_err still set
    step(); base = cyc; dREN = 1'b1; daddr = 32'h500; ramstate = BUSY; ramload = 32'hDEAD_BEEF;
    expect_resp(1'b1, 32'h0, base + 8);
    for (int k = 1; k <= 8; k++) begin
      step(); #1;
      if (k == 1) chk("to_ramREN", {31'b0, ramREN}, 1);
      if (k == 8) chk("to_mem_err_before", {31'b0, mem_err}, 0);
    end
    step(); dREN = 1'b0;
    #1; chk("to_mem_err_set", {31'b0, mem_err}, 1);
    step(); dREN = 1'b1; ramstate = ACCESS; ramload = 32'h33;
    step(); expect_resp(1'b1, 32'h33, base + 11);
    step(); dREN = 1'b0;
    #1; chk("to_mem_err_sticky", {31'b0, mem_err}, 1);

    // Reset asserted during SERVE_D
    step(); dWEN = 1'b1; daddr = 32'h700; dstore = 32'h55; ramstate = BUSY;
    step(); RST = 1'b1;
    #1; chk("rd_ramWEN", {31'b0, ramWEN}, 1);
    chk("rd_ramstore", ramstore, 32'h55);
    step(); #1;
    chk("rd_after_ramWEN", {31'b0, ramWEN}, 0);
    chk("rd_after_ramREN", {31'b0, ramREN}, 0);
    chk("rd_after_ramstore", ramstore, 0);
    chk("rd_after_mem_err", {31'b0, mem_err}, 0);
    step(); RST = 1'b0; dWEN = 1'b0;
    step();

    // Flush abort during SERVE_I
    step(); iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
    step(); #1; chk("fl_ramREN", {31'b0, ramREN}, 1);
    step(); iREN = 1'b0;
    #1; chk("fl_drop_ramREN", {31'b0, ramREN}, 0);
    chk("fl_drop_iwait", {31'b0, iwait}, 1);
    step(); iREN = 1'b1;
    #1; chk("fl_idle_ramREN", {31'b0, ramREN}, 0);
    chk("fl_mem_err", {31'b0, mem_err}, 0);
    step(); ramstate = ACCESS; ramload = 32'h44; expect_resp(1'b0, 32'h44, cyc);
    #1; chk("fl_regrant_ramREN", {31'b0, ramREN}, 1);
    step(); iREN = 1'b0; ramstate = FREE;

    // RAM ERROR completion
    step(); dREN = 1'b1; daddr = 32'h800;
    step(); ramstate = ERROR; ramload = 32'h99; expect_resp(1'b1, 32'h0, cyc);
    step(); dREN = 1'b0; ramstate = FREE;
    #1; chk("er_mem_err", {31'b0, mem_err}, 1);
    step(); step();

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
